// File: rtl/div_iterative_nr_if.sv
// Request/response bundle between the decode stage (master) and the iterative divider (slave).
// Optional DIV_REMAINDER_EN adds the data_remainder response field.
interface div_iterative_nr_if #(parameter int WIDTH = 32);
  logic             ctrl_div;
  logic [WIDTH-1:0] data_operandA;
  logic [WIDTH-1:0] data_operandB;
  logic [WIDTH-1:0] data_result;
  logic             data_exception;
  logic             data_resultRDY;
`ifdef DIV_REMAINDER_EN
  logic [WIDTH-1:0] data_remainder;

  modport master (output ctrl_div, data_operandA, data_operandB,
                  input  data_result, data_exception, data_resultRDY, data_remainder);
  modport slave  (input  ctrl_div, data_operandA, data_operandB,
                  output data_result, data_exception, data_resultRDY, data_remainder);
`else
  modport master (output ctrl_div, data_operandA, data_operandB,
                  input  data_result, data_exception, data_resultRDY);
  modport slave  (input  ctrl_div, data_operandA, data_operandB,
                  output data_result, data_exception, data_resultRDY);
`endif
endinterface

// File: rtl/div_iterative_nr.sv
// Signed non-restoring divider, one quotient bit per clock, sign fix-up in a final cycle.
// Define DIV_REMAINDER_EN to add the corrected, dividend-signed remainder output.

// Conditional-invert-and-add: sum = a + b when sub=0, a - b when sub=1.
module div_addsub_stage #(parameter int W = 33) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  output logic [W-1:0] sum
);
  assign sum = a + (b ^ {W{sub}}) + {{(W-1){1'b0}}, sub};
endmodule

module div_iterative_nr #(parameter int WIDTH = 32) (
  input  logic clock,
  input  logic reset,
  div_iterative_nr_if.slave bus
);
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH:0]   r_q, r_d;
  logic [WIDTH-1:0] q_q, q_d, d_q, d_d;
  logic             sign_q_q, sign_q_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             exc_q, exc_d, rdy_q, rdy_d;

  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   r_shift, r_step;

  // Magnitudes are unsigned, so the most-negative operand maps to 2^(WIDTH-1) exactly.
  assign a_mag   = bus.data_operandA[WIDTH-1] ? -bus.data_operandA : bus.data_operandA;
  assign b_mag   = bus.data_operandB[WIDTH-1] ? -bus.data_operandB : bus.data_operandB;
  assign r_shift = {r_q[WIDTH-1:0], q_q[WIDTH-1]};

  div_addsub_stage #(.W(WIDTH+1)) u_step (
    .a   (r_shift),
    .b   ({1'b0, d_q}),
    .sub (~r_q[WIDTH]),
    .sum (r_step)
  );

`ifdef DIV_REMAINDER_EN
  logic             sign_r_q, sign_r_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH:0]   r_fix, r_corr;

  // A negative partial remainder is restored by one more add of the divisor.
  div_addsub_stage #(.W(WIDTH+1)) u_fix (
    .a   (r_q),
    .b   ({1'b0, d_q}),
    .sub (1'b0),
    .sum (r_fix)
  );
  assign r_corr = r_q[WIDTH] ? r_fix : r_q;
  assign bus.data_remainder = rem_q;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    r_d      = r_q;
    q_d      = q_q;
    d_d      = d_q;
    sign_q_d = sign_q_q;
    result_d = result_q;
    exc_d    = exc_q;
    rdy_d    = 1'b0;
`ifdef DIV_REMAINDER_EN
    sign_r_d = sign_r_q;
    rem_d    = rem_q;
`endif
    // A start strobe aborts whatever is in flight, including a pending FIX.
    if (bus.ctrl_div) begin
      q_d      = a_mag;
      d_d      = b_mag;
      r_d      = '0;
      cnt_d    = '0;
      sign_q_d = bus.data_operandA[WIDTH-1] ^ bus.data_operandB[WIDTH-1];
`ifdef DIV_REMAINDER_EN
      sign_r_d = bus.data_operandA[WIDTH-1];
`endif
      if (bus.data_operandB == '0) begin
        state_d  = DONE;
        exc_d    = 1'b1;
        result_d = '0;
        rdy_d    = 1'b1;
`ifdef DIV_REMAINDER_EN
        rem_d    = '0;
`endif
      end else begin
        state_d  = RUN;
      end
    end else begin
      case (state_q)
        RUN: begin
          r_d   = r_step;
          q_d   = {q_q[WIDTH-2:0], ~r_step[WIDTH]};
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST) state_d = FIX;
        end
        FIX: begin
          result_d = sign_q_q ? -q_q : q_q;
          exc_d    = 1'b0;
          rdy_d    = 1'b1;
          state_d  = DONE;
`ifdef DIV_REMAINDER_EN
          rem_d    = sign_r_q ? -r_corr[WIDTH-1:0] : r_corr[WIDTH-1:0];
`endif
        end
        DONE:    state_d = IDLE;
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      r_q      <= '0;
      q_q      <= '0;
      d_q      <= '0;
      sign_q_q <= 1'b0;
      result_q <= '0;
      exc_q    <= 1'b0;
      rdy_q    <= 1'b0;
`ifdef DIV_REMAINDER_EN
      sign_r_q <= 1'b0;
      rem_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      r_q      <= r_d;
      q_q      <= q_d;
      d_q      <= d_d;
      sign_q_q <= sign_q_d;
      result_q <= result_d;
      exc_q    <= exc_d;
      rdy_q    <= rdy_d;
`ifdef DIV_REMAINDER_EN
      sign_r_q <= sign_r_d;
      rem_q    <= rem_d;
`endif
    end
  end

  assign bus.data_result    = result_q;
  assign bus.data_exception = exc_q;
  assign bus.data_resultRDY = rdy_q;
endmodule

// File: tb/tb_div_iterative_nr.sv
// Directed bench for div_iterative_nr: arithmetic/latency model checked every cycle,
// plus literal expectations for the hand-worked vectors.
module tb_div_iterative_nr;
  localparam int W   = 32;
  localparam int LAT = W + 2; // edges counted from the start edge through E(W+1)

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad   = 0;
  int   rdy_cnt = 0;
  bit   armed = 1'b0;

  div_iterative_nr_if #(.WIDTH(W)) bus ();
  div_iterative_nr #(.WIDTH(W)) dut (.clock(clock), .reset(reset), .bus(bus));

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Model: the answer comes from plain signed arithmetic; timing is a countdown of edges.
  logic [W-1:0] m_result = '0, m_rem = '0, p_result = '0, p_rem = '0;
  logic         m_exc = 1'b0, m_rdy = 1'b0, p_exc = 1'b0;
  int           m_left = 0;

  always @(posedge clock) begin
    longint sa, sb, qq, rr;
    m_rdy = 1'b0;
    if (reset) begin
      m_result = '0; m_rem = '0; m_exc = 1'b0; m_left = 0;
    end else begin
      if (bus.ctrl_div) begin
        sa = $signed(bus.data_operandA);
        sb = $signed(bus.data_operandB);
        if (sb == 0) begin
          p_result = '0; p_rem = '0; p_exc = 1'b1; m_left = 1;
        end else begin
          qq = sa / sb;
          rr = sa % sb;
          p_result = qq[W-1:0]; p_rem = rr[W-1:0]; p_exc = 1'b0; m_left = LAT;
        end
      end
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_result = p_result; m_rem = p_rem; m_exc = p_exc; m_rdy = 1'b1;
        end
      end
    end
  end

  always @(negedge clock) begin
    if (armed) begin
      chk("cyc_rdy", W'(bus.data_resultRDY), W'(m_rdy));
      chk("cyc_result", bus.data_result, m_result);
      chk("cyc_exc", W'(bus.data_exception), W'(m_exc));
`ifdef DIV_REMAINDER_EN
      chk("cyc_rem", bus.data_remainder, m_rem);
`endif
      if (bus.data_resultRDY) rdy_cnt++;
    end
  end

  task automatic start(input logic [W-1:0] a, input logic [W-1:0] b);
    bus.ctrl_div = 1'b1; bus.data_operandA = a; bus.data_operandB = b;
    @(negedge clock);
    bus.ctrl_div = 1'b0;
  endtask

  // Returns the number of edges from the start edge (inclusive) until RDY is seen.
  task automatic run(input logic [W-1:0] a, input logic [W-1:0] b, output int n);
    start(a, b);
    n = 1;
    while (!bus.data_resultRDY && n < 60) begin
      @(negedge clock);
      n++;
    end
  endtask

  typedef struct { logic [W-1:0] a; logic [W-1:0] b; } vec_t;
  vec_t extra[6];

  initial begin
    int n, p0;
    bus.ctrl_div = 1'b0; bus.data_operandA = '0; bus.data_operandB = '0;
    extra[0] = '{32'd7, 32'd100};
    extra[1] = '{32'hFFFF_FFF9, 32'd2};
    extra[2] = '{32'h7FFF_FFFF, 32'd3};
    extra[3] = '{32'hFFFF_FFFF, 32'h8000_0000};
    extra[4] = '{32'h8000_0000, 32'h8000_0000};
    extra[5] = '{32'd0, 32'd5};

    repeat (3) @(negedge clock);
    reset = 1'b0;
    armed = 1'b1;
    chk("rst_result", bus.data_result, '0);
    chk("rst_exc", W'(bus.data_exception), '0);
    chk("rst_rdy", W'(bus.data_resultRDY), '0);

    run(32'd100, 32'd7, n);
    chk("lat_100_7", W'(n), W'(LAT));
    chk("q_100_7", bus.data_result, 32'd14);
    chk("exc_100_7", W'(bus.data_exception), '0);
`ifdef DIV_REMAINDER_EN
    chk("r_100_7", bus.data_remainder, 32'd2);
`endif
    @(negedge clock);
    chk("rdy_one_cycle", W'(bus.data_resultRDY), '0);

    run(32'hFFFF_FF9C, 32'd7, n);
    chk("q_m100_7", bus.data_result, 32'hFFFF_FFF2);
`ifdef DIV_REMAINDER_EN
    chk("r_m100_7", bus.data_remainder, 32'hFFFF_FFFE);
`endif
    @(negedge clock);
    run(32'd100, 32'hFFFF_FFF9, n);
    chk("q_100_m7", bus.data_result, 32'hFFFF_FFF2);
`ifdef DIV_REMAINDER_EN
    chk("r_100_m7", bus.data_remainder, 32'd2);
`endif
    @(negedge clock);

    run(32'd5, 32'd0, n);
    chk("lat_div0", W'(n), 32'd1);
    chk("exc_div0", W'(bus.data_exception), 32'd1);
    chk("q_div0", bus.data_result, '0);
    @(negedge clock);
    run(32'd9, 32'd3, n);
    chk("exc_clear", W'(bus.data_exception), '0);
    chk("q_9_3", bus.data_result, 32'd3);
    @(negedge clock);

    run(32'h8000_0000, 32'hFFFF_FFFF, n);
    chk("q_ovf", bus.data_result, 32'h8000_0000);
    chk("exc_ovf", W'(bus.data_exception), '0);
    @(negedge clock);
    run(32'h8000_0000, 32'd1, n);
    chk("q_min_1", bus.data_result, 32'h8000_0000);
    @(negedge clock);

    foreach (extra[i]) begin
      run(extra[i].a, extra[i].b, n);
      @(negedge clock);
    end

    // Abort: restart at E10 with 50/5.
    p0 = rdy_cnt;
    start(32'd100, 32'd7);
    repeat (9) @(negedge clock);
    run(32'd50, 32'd5, n);
    chk("lat_abort", W'(n), W'(LAT));
    chk("q_abort", bus.data_result, 32'd10);
    @(negedge clock);
    chk("pulses_abort", W'(rdy_cnt - p0), 32'd1);

    // Reset at E15 of an in-flight divide.
    start(32'd100, 32'd7);
    repeat (14) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    p0 = rdy_cnt;
    repeat (40) @(negedge clock);
    chk("pulses_reset", W'(rdy_cnt - p0), '0);
    chk("q_after_reset", bus.data_result, '0);
    chk("exc_after_reset", W'(bus.data_exception), '0);
    run(32'd6, 32'd3, n);
    chk("q_6_3", bus.data_result, 32'd2);
    @(negedge clock);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
